// File: rtl/route_pkg.sv
// Shared types and helpers for the route sequencer and its path buffer.
package route_pkg;

    localparam int DEF_NULL_NODE = 27;
    localparam int MAX_NODE_W    = 16;
    localparam int MAX_PATH_BITS = 1024;

    typedef enum logic [3:0] {
        IDLE, LOAD_SEG, PLAN_REQ, PLAN_WAIT, SCAN, WAIT_NODE, TURN, SEG_NEXT, ERR
    } route_state_e;

    // Index width that never collapses to zero bits for single-entry tables.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entry idx of a flat planner path, node_w bits per entry, entry 0 in the LSBs.
    function automatic logic [MAX_NODE_W-1:0] path_entry(input logic [MAX_PATH_BITS-1:0] path,
                                                        input int idx, input int node_w);
        logic [MAX_NODE_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_NODE_W; b++)
            if (b < node_w && (idx * node_w + b) < MAX_PATH_BITS)
                r[b] = path[idx * node_w + b];
        return r;
    endfunction

endpackage

// File: rtl/route_path_buffer.sv
// Holds the captured planner path and a cursor that walks it from the top
// entry down to entry 0 (end node); exposes neighbours of the cursor.
module route_path_buffer
    import route_pkg::*;
#(
    parameter int NODE_W    = 5,
    parameter int PATH_LEN  = 10,
    parameter int NULL_NODE = DEF_NULL_NODE,
    parameter int PIDX_W    = idx_w(PATH_LEN)
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       cap_en,
    input  logic                       step,
    input  logic [NODE_W*PATH_LEN-1:0] plan_path,
    output logic [PIDX_W-1:0]          cursor,
    output logic [NODE_W-1:0]          cur_node,
    output logic [NODE_W-1:0]          up_node,
    output logic [NODE_W-1:0]          dn_node,
    output logic [NODE_W-1:0]          end_node,
    output logic                       at_pad,
    output logic                       all_null
);

    localparam logic [NODE_W-1:0] NULL_V  = NODE_W'(NULL_NODE);
    localparam logic [PIDX_W-1:0] TOP_IDX = PIDX_W'(PATH_LEN - 1);

    logic [NODE_W-1:0] path_q  [PATH_LEN];
    logic [NODE_W-1:0] path_in [PATH_LEN];
    logic [PIDX_W-1:0] k_q;

    for (genvar i = 0; i < PATH_LEN; i++) begin : g_unpack
        assign path_in[i] = NODE_W'(path_entry(MAX_PATH_BITS'(plan_path), i, NODE_W));
    end

    // Capture restarts the cursor at the top entry; step walks it toward entry 0.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < PATH_LEN; i++) path_q[i] <= NULL_V;
            k_q <= TOP_IDX;
        end else if (cap_en) begin
            path_q <= path_in;
            k_q    <= TOP_IDX;
        end else if (step && k_q != '0) begin
            k_q <= k_q - 1'b1;
        end
    end

    assign cursor   = k_q;
    assign cur_node = path_q[k_q];
    assign up_node  = (k_q == TOP_IDX) ? NULL_V : path_q[k_q + 1'b1];
    assign dn_node  = (k_q == '0) ? NULL_V : path_q[k_q - 1'b1];
    assign end_node = path_q[0];
    assign at_pad   = (cur_node == NULL_V);
    assign all_null = at_pad && (k_q == '0);

endmodule

// File: rtl/route_sequencer.sv
// Multi-segment route executor: plans each (start,end) table pair, then walks
// the returned path one junction at a time, issuing turn triples.
module route_sequencer
    import route_pkg::*;
#(
    parameter int NODE_W       = 5,
    parameter int PATH_LEN     = 10,
    parameter int NUM_SEG      = 3,
    parameter int NULL_NODE    = DEF_NULL_NODE,
    parameter int PLAN_TIMEOUT = 1000000,
    parameter int CNT_W        = $clog2(NUM_SEG + 1),
    parameter int SIDX_W       = idx_w(NUM_SEG)
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_W-1:0]           seg_count,
    input  logic                       seg_wr_en,
    input  logic [SIDX_W-1:0]          seg_wr_idx,
    input  logic [NODE_W-1:0]          seg_wr_s,
    input  logic [NODE_W-1:0]          seg_wr_e,
    output logic                       plan_start,
    output logic [NODE_W-1:0]          plan_s_node,
    output logic [NODE_W-1:0]          plan_e_node,
    input  logic                       plan_done,
    input  logic [NODE_W*PATH_LEN-1:0] plan_path,
    input  logic                       node_reached,
    output logic                       turn_req,
    output logic [NODE_W-1:0]          prev_node,
    output logic [NODE_W-1:0]          curr_node,
    output logic [NODE_W-1:0]          next_node,
    input  logic                       turn_done,
    output logic [SIDX_W-1:0]          seg_idx,
    output logic                       busy,
    output logic                       route_done,
    output logic                       error
);

    localparam int                 PIDX_W  = idx_w(PATH_LEN);
    localparam int                 TMO_W   = $clog2(PLAN_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_MAX = TMO_W'(PLAN_TIMEOUT - 1);
    localparam logic [NODE_W-1:0]  NULL_V  = NODE_W'(NULL_NODE);

    route_state_e state_q, state_d;

    logic [NODE_W-1:0] tbl_s [NUM_SEG];
    logic [NODE_W-1:0] tbl_e [NUM_SEG];
    logic [SIDX_W-1:0] seg_idx_q;
    logic [CNT_W-1:0]  seg_cnt_q;
    logic [NODE_W-1:0] carry_prev;
    logic [PIDX_W-1:0] top_k;
    logic [TMO_W-1:0]  tmo_q;
    logic [NODE_W-1:0] plan_s_q, plan_e_q, prev_q, curr_q, next_q;

    logic              cap_en, buf_step, last_seg;
    logic [PIDX_W-1:0] cursor;
    logic [NODE_W-1:0] cur_node, up_node, dn_node, end_node;
    logic              at_pad, all_null;

    route_path_buffer #(
        .NODE_W(NODE_W), .PATH_LEN(PATH_LEN), .NULL_NODE(NULL_NODE)
    ) u_path (
        .clk_50(clk_50), .reset(reset), .cap_en(cap_en), .step(buf_step),
        .plan_path(plan_path), .cursor(cursor), .cur_node(cur_node),
        .up_node(up_node), .dn_node(dn_node), .end_node(end_node),
        .at_pad(at_pad), .all_null(all_null)
    );

    assign last_seg = ((CNT_W'(seg_idx_q) + 1'b1) == seg_cnt_q);

    // State register.
    always_ff @(posedge clk_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode, control strobes and status outputs.
    always_comb begin
        state_d    = state_q;
        cap_en     = 1'b0;
        buf_step   = 1'b0;
        plan_start = (state_q == PLAN_REQ);
        turn_req   = (state_q == TURN);
        busy       = (state_q != IDLE);
        error      = (state_q == ERR);
        route_done = (state_q == SEG_NEXT) && last_seg;
        unique case (state_q)
            IDLE:
                if (start)
                    state_d = (seg_count == '0 || {1'b0, seg_count} > (CNT_W+1)'(NUM_SEG))
                              ? ERR : LOAD_SEG;
            LOAD_SEG:
                state_d = (seg_idx_q != '0 && tbl_s[seg_idx_q] != plan_e_q) ? ERR : PLAN_REQ;
            PLAN_REQ:
                state_d = PLAN_WAIT;
            PLAN_WAIT:
                if (plan_done) begin
                    cap_en  = 1'b1;
                    state_d = SCAN;
                end else if (tmo_q == TMO_MAX) begin
                    state_d = ERR;
                end
            SCAN:
                if (at_pad) begin
                    if (all_null) state_d = ERR;
                    else          buf_step = 1'b1;
                end else if (cur_node != plan_s_q || end_node != plan_e_q) begin
                    state_d = ERR;
                end else begin
                    state_d = WAIT_NODE;
                end
            WAIT_NODE:
                if (node_reached) state_d = (cursor == '0) ? SEG_NEXT : TURN;
            TURN:
                if (turn_done) begin
                    buf_step = 1'b1;
                    state_d  = WAIT_NODE;
                end
            SEG_NEXT:
                state_d = last_seg ? IDLE : LOAD_SEG;
            ERR:
                state_d = ERR;
            default:
                state_d = IDLE;
        endcase
    end

    // Segment table, planner request nodes, timeout counter and turn triple.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                tbl_s[i] <= NULL_V;
                tbl_e[i] <= NULL_V;
            end
            seg_idx_q  <= '0;
            seg_cnt_q  <= '0;
            carry_prev <= NULL_V;
            top_k      <= '0;
            tmo_q      <= '0;
            plan_s_q   <= '0;
            plan_e_q   <= '0;
            prev_q     <= NULL_V;
            curr_q     <= NULL_V;
            next_q     <= NULL_V;
        end else begin
            if (state_q == IDLE && seg_wr_en && {1'b0, seg_wr_idx} < (SIDX_W+1)'(NUM_SEG)) begin
                tbl_s[seg_wr_idx] <= seg_wr_s;
                tbl_e[seg_wr_idx] <= seg_wr_e;
            end
            unique case (state_q)
                IDLE:
                    if (start) begin
                        seg_cnt_q  <= seg_count;
                        seg_idx_q  <= '0;
                        carry_prev <= NULL_V;
                    end
                LOAD_SEG: begin
                    plan_s_q <= tbl_s[seg_idx_q];
                    plan_e_q <= tbl_e[seg_idx_q];
                end
                PLAN_REQ:  tmo_q <= '0;
                PLAN_WAIT: if (!plan_done) tmo_q <= tmo_q + 1'b1;
                SCAN:      if (!at_pad) top_k <= cursor;
                WAIT_NODE:
                    if (node_reached) begin
                        curr_q <= cur_node;
                        if (cursor != '0) begin
                            // The segment's first junction inherits its predecessor
                            // from the previous segment's path.
                            prev_q <= (cursor == top_k) ? carry_prev : up_node;
                            next_q <= dn_node;
                        end
                    end
                SEG_NEXT:
                    if (!last_seg) begin
                        carry_prev <= up_node;
                        seg_idx_q  <= seg_idx_q + 1'b1;
                    end
                default: ;
            endcase
        end
    end

    assign plan_s_node = plan_s_q;
    assign plan_e_node = plan_e_q;
    assign prev_node   = prev_q;
    assign curr_node   = curr_q;
    assign next_node   = next_q;
    assign seg_idx     = seg_idx_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Self-checking bench for route_sequencer with a planner responder and a
// list-based route model.
module tb_route_sequencer;

    localparam int NW = 5, PL = 10, NS = 3, NUL = 27, TMO = 100;

    logic            clk_50 = 1'b0;
    logic            reset, start, seg_wr_en, plan_done, node_reached, turn_done;
    logic [1:0]      seg_count, seg_wr_idx, seg_idx;
    logic [NW-1:0]   seg_wr_s, seg_wr_e, plan_s_node, plan_e_node;
    logic [NW-1:0]   prev_node, curr_node, next_node;
    logic [NW*PL-1:0] plan_path;
    logic            plan_start, turn_req, busy, route_done, error;

    int total = 0, bad = 0;
    int plan_cnt = 0, done_cnt = 0;
    bit plan_en = 1'b1;
    logic [NW*PL-1:0] plan_q[$];
    logic [2*NW-1:0]  se_q[$];
    logic [NW*PL-1:0] rsp_path;
    logic [2*NW-1:0]  rsp_se;
    int segs[NS][$];

    always #5 clk_50 = ~clk_50;

    route_sequencer #(.NODE_W(NW), .PATH_LEN(PL), .NUM_SEG(NS), .NULL_NODE(NUL),
                      .PLAN_TIMEOUT(TMO)) dut (
        .clk_50(clk_50), .reset(reset), .start(start), .seg_count(seg_count),
        .seg_wr_en(seg_wr_en), .seg_wr_idx(seg_wr_idx), .seg_wr_s(seg_wr_s),
        .seg_wr_e(seg_wr_e), .plan_start(plan_start), .plan_s_node(plan_s_node),
        .plan_e_node(plan_e_node), .plan_done(plan_done), .plan_path(plan_path),
        .node_reached(node_reached), .turn_req(turn_req), .prev_node(prev_node),
        .curr_node(curr_node), .next_node(next_node), .turn_done(turn_done),
        .seg_idx(seg_idx), .busy(busy), .route_done(route_done), .error(error)
    );

    // Planner stand-in: answers each request with the next queued path.
    always begin
        @(negedge clk_50);
        if (plan_start === 1'b1) begin
            plan_cnt++;
            if (plan_en && plan_q.size() > 0) begin
                rsp_path = plan_q.pop_front();
                rsp_se   = se_q.pop_front();
                total++;
                if ({plan_s_node, plan_e_node} !== rsp_se) begin
                    bad++;
                    $display("FAIL plan_nodes: got s=%0d e=%0d want s=%0d e=%0d",
                             plan_s_node, plan_e_node, rsp_se[2*NW-1:NW], rsp_se[NW-1:0]);
                end
                repeat (3) @(posedge clk_50);
                #1 plan_path = rsp_path; plan_done = 1'b1;
                @(posedge clk_50);
                #1 plan_done = 1'b0;
            end
        end
    end

    always @(negedge clk_50) if (route_done === 1'b1) done_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Travel-order node list -> planner format (entry 0 = end, pads above).
    function automatic logic [NW*PL-1:0] pack_path(input int l[$]);
        logic [NW*PL-1:0] p;
        for (int i = 0; i < PL; i++) p[i*NW +: NW] = NW'(NUL);
        for (int i = 0; i < l.size(); i++) p[i*NW +: NW] = NW'(l[l.size()-1-i]);
        return p;
    endfunction

    function automatic int rand_node();
        int v = $urandom_range(0, 30);
        return (v >= NUL) ? v + 1 : v;
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; node_reached = 1'b0; turn_done = 1'b0;
        plan_done = 1'b0; seg_wr_en = 1'b0; plan_en = 1'b1;
        plan_q.delete(); se_q.delete();
        repeat (2) @(posedge clk_50);
        #1 reset = 1'b0;
    endtask

    task automatic write_seg(input int idx, input int s, input int e);
        @(posedge clk_50);
        #1 seg_wr_en = 1'b1; seg_wr_idx = 2'(idx); seg_wr_s = NW'(s); seg_wr_e = NW'(e);
        @(posedge clk_50);
        #1 seg_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk_50);
        #1 start = 1'b1; seg_count = 2'(n);
        @(posedge clk_50);
        #1 start = 1'b0;
    endtask

    // One junction event. mode 1: extra node_reached during TURN; mode 2:
    // node_reached coincident with turn_done. Both must be ignored.
    task automatic node_event(input bit has_turn, input int ep, input int ec, input int en,
                              input int mode);
        int w = 0;
        repeat (25) @(posedge clk_50);
        #1 node_reached = 1'b1;
        @(posedge clk_50);
        #1 node_reached = 1'b0;
        @(negedge clk_50);
        if (!has_turn) begin
            total++;
            if (curr_node !== NW'(ec) || turn_req !== 1'b0) begin
                bad++;
                $display("FAIL end_node: got curr=%0d turn_req=%b want curr=%0d turn_req=0",
                         curr_node, turn_req, ec);
            end
            return;
        end
        while (turn_req !== 1'b1 && w < 5) begin @(negedge clk_50); w++; end
        total++;
        if (turn_req !== 1'b1) begin
            bad++;
            $display("FAIL turn_req_wait: got turn_req=%b want 1", turn_req);
            return;
        end
        total++;
        if ({prev_node, curr_node, next_node} !== {NW'(ep), NW'(ec), NW'(en)}) begin
            bad++;
            $display("FAIL triple: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     prev_node, curr_node, next_node, ep, ec, en);
        end
        if (mode == 1) begin
            @(posedge clk_50); #1 node_reached = 1'b1;
            @(posedge clk_50); #1 node_reached = 1'b0;
            repeat (2) @(negedge clk_50);
            total++;
            if (turn_req !== 1'b1 || curr_node !== NW'(ec)) begin
                bad++;
                $display("FAIL turn_hold: got turn_req=%b curr=%0d want 1 %0d",
                         turn_req, curr_node, ec);
            end
        end
        @(posedge clk_50);
        #1 turn_done = 1'b1; node_reached = (mode == 2);
        @(posedge clk_50);
        #1 turn_done = 1'b0; node_reached = 1'b0;
        @(negedge clk_50);
        total++;
        if (turn_req !== 1'b0) begin
            bad++;
            $display("FAIL turn_release: got turn_req=%b want 0", turn_req);
        end
    endtask

    // Programs segs[0..n-1], runs the whole route and checks it against the
    // list model: triples walk each list; first prev is carried from the
    // previous segment's second-to-last node.
    task automatic run_route(input int n, input bit wr_busy);
        int L[$];
        int carry, p0, d0, len;
        for (int j = 0; j < n; j++) begin
            L = segs[j];
            write_seg(j, L[0], L[L.size()-1]);
            plan_q.push_back(pack_path(L));
            se_q.push_back({NW'(L[0]), NW'(L[L.size()-1])});
        end
        p0 = plan_cnt; d0 = done_cnt; carry = NUL;
        pulse_start(n);
        if (wr_busy) write_seg(1, 20, 21);
        for (int j = 0; j < n; j++) begin
            L = segs[j];
            len = L.size();
            for (int i = 0; i < len - 1; i++)
                node_event(1'b1, (i == 0) ? carry : L[i-1], L[i], L[i+1], $urandom_range(0, 2));
            if (j == n - 1) begin
                total++;
                if (done_cnt !== d0) begin
                    bad++;
                    $display("FAIL early_route_done: got %0d pulses want 0", done_cnt - d0);
                end
            end
            node_event(1'b0, 0, L[len-1], 0, 0);
            carry = L[len-2];
        end
        repeat (3) @(negedge clk_50);
        total++;
        if (done_cnt !== d0 + 1 || busy !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL route_end: got done=%0d busy=%b error=%b want 1 0 0",
                     done_cnt - d0, busy, error);
        end
        total++;
        if (plan_cnt !== p0 + n) begin
            bad++;
            $display("FAIL plan_count: got %0d want %0d", plan_cnt - p0, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_50);
        total++;
        if ({busy, error, turn_req, plan_start, route_done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, error, turn_req, plan_start, route_done});
        end
        total++;
        if ({prev_node, curr_node, next_node} !== {NW'(NUL), NW'(NUL), NW'(NUL)}) begin
            bad++;
            $display("FAIL reset_triple: got (%0d,%0d,%0d) want all %0d",
                     prev_node, curr_node, next_node, NUL);
        end
        total++;
        if ({seg_idx, plan_s_node, plan_e_node} !== '0) begin
            bad++;
            $display("FAIL reset_regs: got seg_idx=%0d s=%0d e=%0d want 0",
                     seg_idx, plan_s_node, plan_e_node);
        end
    endtask

    task automatic test_directed();
        do_reset();
        segs[0] = {0, 1, 2, 3};
        segs[1] = {3, 4, 5, 8};
        segs[2] = {8, 9, 14};
        run_route(3, 1'b1);
    endtask

    task automatic test_random();
        int node, len, n;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            n = $urandom_range(1, NS);
            node = rand_node();
            for (int j = 0; j < n; j++) begin
                segs[j].delete();
                segs[j].push_back(node);
                len = $urandom_range(2, PL);
                for (int i = 1; i < len; i++) begin
                    node = rand_node();
                    segs[j].push_back(node);
                end
            end
            run_route(n, 1'b0);
        end
    endtask

    // A seg_count of 4 does not fit the 2-bit port when NUM_SEG=3; 0 is the
    // reachable out-of-range value.
    task automatic test_bad_count();
        int p0;
        do_reset();
        write_seg(0, 0, 3);
        p0 = plan_cnt;
        pulse_start(0);
        @(negedge clk_50);
        total++;
        if (error !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bad_count: got error=%b busy=%b want 1 1", error, busy);
        end
        repeat (10) @(negedge clk_50);
        total++;
        if (plan_cnt !== p0) begin
            bad++;
            $display("FAIL bad_count_plan: got %0d plan_start want 0", plan_cnt - p0);
        end
    endtask

    task automatic test_discontinuity();
        int p0;
        do_reset();
        write_seg(0, 0, 3);
        write_seg(1, 5, 8);
        plan_q.push_back(pack_path({0, 1, 2, 3}));
        se_q.push_back({NW'(0), NW'(3)});
        p0 = plan_cnt;
        pulse_start(2);
        node_event(1'b1, NUL, 0, 1, 0);
        node_event(1'b1, 0, 1, 2, 0);
        node_event(1'b1, 1, 2, 3, 0);
        node_event(1'b0, 0, 3, 0, 0);
        repeat (5) @(negedge clk_50);
        total++;
        if (error !== 1'b1 || plan_cnt !== p0 + 1) begin
            bad++;
            $display("FAIL discontinuity: got error=%b plans=%0d want 1 1", error, plan_cnt - p0);
        end
    endtask

    task automatic test_timeout();
        int w = 0;
        do_reset();
        plan_en = 1'b0;
        write_seg(0, 0, 3);
        pulse_start(1);
        @(negedge clk_50);
        while (plan_start !== 1'b1 && w < 10) begin @(negedge clk_50); w++; end
        total++;
        if (plan_start !== 1'b1) begin
            bad++;
            $display("FAIL timeout_plan_start: got 0 want 1");
            return;
        end
        repeat (99) @(posedge clk_50);
        @(negedge clk_50);
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got error=%b want 0", error);
        end
        repeat (2) @(posedge clk_50);
        @(negedge clk_50);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_late: got error=%b want 1", error);
        end
    endtask

    task automatic test_bad_path();
        logic [NW*PL-1:0] p;
        for (int c = 0; c < 3; c++) begin
            do_reset();
            write_seg(0, 0, 3);
            if (c == 0)      for (int i = 0; i < PL; i++) p[i*NW +: NW] = NW'(NUL);
            else if (c == 1) p = pack_path({0, 1, 7});
            else             p = pack_path({4, 1, 3});
            plan_q.push_back(p);
            se_q.push_back({NW'(0), NW'(3)});
            pulse_start(1);
            repeat (30) @(negedge clk_50);
            total++;
            if (error !== 1'b1 || turn_req !== 1'b0) begin
                bad++;
                $display("FAIL bad_path%0d: got error=%b turn_req=%b want 1 0", c, error, turn_req);
            end
        end
    endtask

    task automatic test_reset_in_turn();
        int p0, w = 0;
        do_reset();
        write_seg(0, 0, 3);
        write_seg(1, 3, 8);
        plan_q.push_back(pack_path({0, 1, 2, 3}));
        se_q.push_back({NW'(0), NW'(3)});
        pulse_start(2);
        repeat (25) @(posedge clk_50);
        #1 node_reached = 1'b1;
        @(posedge clk_50);
        #1 node_reached = 1'b0;
        @(negedge clk_50);
        while (turn_req !== 1'b1 && w < 5) begin @(negedge clk_50); w++; end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_50); #1 node_reached = 1'b1;
            @(posedge clk_50); #1 node_reached = 1'b0;
        end
        @(negedge clk_50);
        total++;
        if (turn_req !== 1'b1 || {prev_node, curr_node, next_node} !== {NW'(NUL), NW'(0), NW'(1)}) begin
            bad++;
            $display("FAIL turn_ignore_node: got req=%b (%0d,%0d,%0d) want 1 (27,0,1)",
                     turn_req, prev_node, curr_node, next_node);
        end
        p0 = plan_cnt;
        @(posedge clk_50);
        #1 reset = 1'b1;
        @(posedge clk_50);
        #1 reset = 1'b0;
        @(negedge clk_50);
        total++;
        if (turn_req !== 1'b0 || busy !== 1'b0 || curr_node !== NW'(NUL)) begin
            bad++;
            $display("FAIL reset_in_turn: got req=%b busy=%b curr=%0d want 0 0 27",
                     turn_req, busy, curr_node);
        end
        repeat (20) @(negedge clk_50);
        total++;
        if (plan_cnt !== p0 || turn_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: got plans=%0d req=%b want 0 0", plan_cnt - p0, turn_req);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; seg_count = '0; seg_wr_en = 1'b0; seg_wr_idx = '0;
        seg_wr_s = '0; seg_wr_e = '0; plan_done = 1'b0; plan_path = '0;
        node_reached = 1'b0; turn_done = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_bad_count();
        test_discontinuity();
        test_timeout();
        test_bad_path();
        test_reset_in_turn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
